// File: rtl/combo_verdict.sv
// combo_verdict: stage sequencer, open/fail verdict, attempt counter and lockout for the combination lock.
// Optional: define COMBO_ALARM_LATCH_EN to make LOCKOUT permanent until reset.
module combo_verdict #(
    parameter int NUM_STAGES     = 3,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int OPEN_CYCLES    = 50000000,
    parameter int FAIL_CYCLES    = 25000000,
    parameter int LOCKOUT_CYCLES = 250000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pair_valid,
    input  logic       pair_match,
    input  logic       cancel,
    output logic [1:0] stage,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] attempts_left,
    output logic [6:0] status_seg
);
    localparam int OF_MAX = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
`ifdef COMBO_ALARM_LATCH_EN
    localparam int T_MAX = OF_MAX;
`else
    localparam int T_MAX = (LOCKOUT_CYCLES > OF_MAX) ? LOCKOUT_CYCLES : OF_MAX;
`endif
    localparam int TW = $clog2(T_MAX) + 1;

    typedef enum logic [1:0] {ENTRY, OPEN, FAIL, LOCKOUT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  stage_q, stage_d;
    logic        all_ok_q, all_ok_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]  att_q, att_d;
    logic        unlocked_q, alarm_q;
    logic [6:0]  seg_q, seg_d;

    // Active-low segment pattern for the state being entered
    always_comb begin
        seg_d = (state_d == OPEN)    ? ~7'h3E :
                (state_d == FAIL)    ? ~7'h71 :
                (state_d == LOCKOUT) ? ~7'h38 :
                (stage_d == 2'd0)    ? ~7'h3F :
                (stage_d == 2'd1)    ? ~7'h06 :
                (stage_d == 2'd2)    ? ~7'h5B : ~7'h4F;
    end

    // Next-state: digit sequencing in ENTRY, timed holds elsewhere
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        all_ok_d = all_ok_q;
        timer_d  = timer_q;
        att_d    = att_q;
        case (state_q)
            ENTRY: begin
                if (cancel) begin
                    stage_d  = 2'd0;
                    all_ok_d = 1'b1;
                end else if (pair_valid) begin
                    all_ok_d = all_ok_q & pair_match;
                    if (stage_q == 2'(NUM_STAGES - 1)) begin
                        stage_d = 2'd0;
                        if (all_ok_q & pair_match) begin
                            state_d = OPEN;
                            timer_d = TW'(OPEN_CYCLES - 1);
                        end else begin
                            state_d = FAIL;
                            timer_d = TW'(FAIL_CYCLES - 1);
                            att_d   = (att_q == 2'd0) ? 2'd0 : att_q - 2'd1;
                        end
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end
            end
            OPEN: begin
                if (timer_q == '0) begin
                    state_d  = ENTRY;
                    att_d    = 2'(MAX_ATTEMPTS);
                    all_ok_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            FAIL: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (att_q == 2'd0) begin
                    state_d = LOCKOUT;
`ifndef COMBO_ALARM_LATCH_EN
                    timer_d = TW'(LOCKOUT_CYCLES - 1);
`endif
                end else begin
                    state_d  = ENTRY;
                    all_ok_d = 1'b1;
                end
            end
            LOCKOUT: begin
`ifndef COMBO_ALARM_LATCH_EN
                if (timer_q == '0) begin
                    state_d  = ENTRY;
                    att_d    = 2'(MAX_ATTEMPTS);
                    all_ok_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
`endif
            end
            default: state_d = ENTRY;
        endcase
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ENTRY;
            stage_q    <= 2'd0;
            all_ok_q   <= 1'b1;
            timer_q    <= '0;
            att_q      <= 2'(MAX_ATTEMPTS);
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            seg_q      <= ~7'h3F;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            all_ok_q   <= all_ok_d;
            timer_q    <= timer_d;
            att_q      <= att_d;
            unlocked_q <= (state_d == OPEN);
            alarm_q    <= (state_d == LOCKOUT);
            seg_q      <= seg_d;
        end
    end

    assign stage         = stage_q;
    assign unlocked      = unlocked_q;
    assign alarm         = alarm_q;
    assign attempts_left = att_q;
    assign status_seg    = seg_q;
endmodule

// File: tb/tb_combo_verdict.sv
// tb_combo_verdict: directed vectors for combo_verdict with short hold times.
module tb_combo_verdict;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pair_valid = 1'b0;
    logic       pair_match = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] stage;
    logic       unlocked;
    logic       alarm;
    logic [1:0] attempts_left;
    logic [6:0] status_seg;
    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] SEG0 = 7'h40, SEG1 = 7'h79, SEG2 = 7'h24;
    localparam logic [6:0] SEGU = 7'h41, SEGF = 7'h0E, SEGL = 7'h47;

    combo_verdict #(
        .NUM_STAGES(3), .MAX_ATTEMPTS(3), .OPEN_CYCLES(4), .FAIL_CYCLES(2), .LOCKOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset), .pair_valid(pair_valid), .pair_match(pair_match),
        .cancel(cancel), .stage(stage), .unlocked(unlocked), .alarm(alarm),
        .attempts_left(attempts_left), .status_seg(status_seg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pair(input logic m);
        pair_valid = 1'b1;
        pair_match = m;
        @(negedge clock);
        pair_valid = 1'b0;
        pair_match = 1'b0;
    endtask

    task automatic code(input logic a, input logic b, input logic c);
        pair(a);
        pair(b);
        pair(c);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_stage", stage, 0);
        check("rst_unlocked", unlocked, 0);
        check("rst_alarm", alarm, 0);
        check("rst_att", attempts_left, 3);
        check("rst_seg", status_seg, SEG0);
        reset = 1'b1;
        @(negedge clock);

        pair(1);
        check("ok_stage1", stage, 1);
        check("ok_seg1", status_seg, SEG1);
        pair(1);
        check("ok_stage2", stage, 2);
        check("ok_seg2", status_seg, SEG2);
        pair(1);
        check("ok_stage0", stage, 0);
        check("ok_seg_u", status_seg, SEGU);
        check("ok_att", attempts_left, 3);
        for (int i = 0; i < 4; i++) begin
            check("ok_unlocked", unlocked, 1);
            @(negedge clock);
        end
        check("ok_relock", unlocked, 0);
        check("ok_seg_back", status_seg, SEG0);

        pair(1);
        pair(0);
        check("mid_stage2", stage, 2);
        check("mid_unlocked", unlocked, 0);
        pair(1);
        check("mid_seg_f", status_seg, SEGF);
        check("mid_att", attempts_left, 2);
        check("mid_unlocked_f", unlocked, 0);
        @(negedge clock);
        check("mid_seg_f2", status_seg, SEGF);
        @(negedge clock);
        check("mid_seg_back", status_seg, SEG0);

        code(0, 1, 1);
        check("w2_att", attempts_left, 1);
        repeat (2) @(negedge clock);
        code(1, 1, 0);
        check("w3_att", attempts_left, 0);
        check("w3_seg_f", status_seg, SEGF);
        check("w3_alarm_f", alarm, 0);
        repeat (2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            check("lock_alarm", alarm, 1);
            check("lock_seg", status_seg, SEGL);
            @(negedge clock);
        end
`ifdef COMBO_ALARM_LATCH_EN
        repeat (100) @(negedge clock);
        check("latch_alarm", alarm, 1);
        pair(1);
        check("latch_ignore", stage, 0);
        reset = 1'b0;
        #1;
        check("latch_clear", alarm, 0);
        check("latch_att", attempts_left, 3);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
`else
        check("lock_exit_alarm", alarm, 0);
        check("lock_exit_att", attempts_left, 3);
        check("lock_exit_seg", status_seg, SEG0);
`endif

        pair(1);
        pair(1);
        check("cxl_stage2", stage, 2);
        cancel = 1'b1;
        pair_valid = 1'b1;
        pair_match = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        pair_valid = 1'b0;
        check("cxl_stage0", stage, 0);
        check("cxl_unlocked", unlocked, 0);
        check("cxl_att", attempts_left, 3);
        check("cxl_seg", status_seg, SEG0);
        code(1, 1, 1);
        check("cxl_open", unlocked, 1);
        repeat (4) @(negedge clock);

        code(1, 1, 0);
        check("rmo_att2", attempts_left, 2);
        repeat (2) @(negedge clock);
        code(1, 1, 1);
        check("rmo_open", unlocked, 1);
        @(negedge clock);
        check("rmo_open2", unlocked, 1);
        #2 reset = 1'b0;
        #1;
        check("rmo_unlocked", unlocked, 0);
        check("rmo_stage", stage, 0);
        check("rmo_att", attempts_left, 3);
        check("rmo_seg", status_seg, SEG0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rmo_stay", unlocked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
